deserializer_ctrl: RTL and testbench

DESERIALIZER_CTRL -- requirements
Module: deserializer_ctrl

---
 rtl/da_ser_pkg.sv | 21 ++
 rtl/ser_tick_gen.sv | 37 +++
 rtl/deserializer_ctrl.sv | 121 ++++++++++++
 tb/tb_deserializer_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_ser_pkg.sv
`default_nettype none
// ============================================================================
// da_ser_pkg : shared FSM encoding and sizing for the serializer front-end
// Rev 1.0
// ============================================================================
package da_ser_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 2;
    localparam int unsigned PHASE_W         = 8;
    localparam int unsigned BIT_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_WAIT     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ser_tick_gen.sv
`default_nettype none
// ============================================================================
// ser_tick_gen : one-cycle tick every CLK_DIV cycles while run_i is high
// Rev 1.0
// ============================================================================
module ser_tick_gen
    import da_ser_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic tick_o
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CLK_DIV - 1);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // Dropping run_i restarts the count so every state begins a fresh half-period.
    always_comb begin
        tick_o  = run_i && (phase_q == LAST_PHASE);
        phase_d = (!run_i || tick_o) ? '0 : phase_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/deserializer_ctrl.sv
`default_nettype none
// ============================================================================
// deserializer_ctrl : drives a 74165-style serializer and delivers bytes
// Rev 1.0
// ============================================================================
module deserializer_ctrl
    import da_ser_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        clk_ser,
    output logic        clk_par,
    input  logic        data_ser,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] frame_count
);

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_q;
    logic [7:0]         shift_q;
    logic               pending_q, pending_d;
    logic               clk_ser_q, clk_par_q, busy_q, m_valid_q;
    logic [7:0]         m_data_q;
    logic [15:0]        frame_count_q;
    logic               tick;
    logic               run;
    logic               slot_free;
    logic               xfer;

    assign run = (state_q == ST_LOAD) || (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);

    ser_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .run_i  (run),
        .tick_o (tick)
    );

    // Every frame passes through WAIT for at least one cycle; pending_q marks
    // a byte that could not be handed over yet and still lives in shift_q.
    always_comb begin
        slot_free = !m_valid_q || m_ready;
        state_d   = state_q;
        pending_d = pending_q;
        xfer      = 1'b0;
        case (state_q)
            ST_IDLE:     if (enable) state_d = ST_LOAD;
            ST_LOAD:     if (tick) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d   = ST_WAIT;
                        xfer      = slot_free;
                        pending_d = !slot_free;
                    end else begin
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_WAIT: begin
                if (!pending_q || slot_free) begin
                    xfer      = pending_q;
                    pending_d = 1'b0;
                    state_d   = enable ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_q         <= '0;
            shift_q       <= '0;
            pending_q     <= 1'b0;
            clk_ser_q     <= 1'b0;
            clk_par_q     <= 1'b1;
            busy_q        <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            frame_count_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            clk_ser_q <= (state_d == ST_SHIFT_HI);
            clk_par_q <= (state_d != ST_LOAD);
            busy_q    <= (state_d != ST_IDLE);
            if (state_q == ST_SHIFT_LO && tick) begin
                shift_q[3'd7 - bit_q] <= data_ser;
            end
            // Bit index wraps 7 -> 0, ready for the next frame.
            if (state_q == ST_SHIFT_HI && tick) begin
                bit_q <= bit_q + 3'd1;
            end
            if (xfer) begin
                m_data_q      <= shift_q;
                m_valid_q     <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign clk_ser     = clk_ser_q;
    assign clk_par     = clk_par_q;
    assign busy        = busy_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_deserializer_ctrl : scoreboard bench with 74165 serializer models
// Rev 1.0
// ============================================================================
module tb_deserializer_ctrl;
    import da_ser_pkg::*;

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] c;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en_a, en_b, rdy_a, rdy_b;
    logic        cs_a, cp_a, ds_a, mv_a, bz_a;
    logic        cs_b, cp_b, ds_b, mv_b, bz_b;
    logic [7:0]  md_a, md_b;
    logic [15:0] fc_a, fc_b;
    logic [7:0]  sreg_a, sreg_b;
    logic        ppar_a, pser_a, ppar_b, pser_b;
    logic        pv_a, prdy_a;
    logic [7:0]  pd_a;
    logic [15:0] cnt_a, cnt_b;
    int          cyc;
    int          n_cmp, n_err;
    logic [7:0]  stim_a[$], stim_b[$];
    exp_t        exp_a[$], exp_b[$];

    deserializer_ctrl #(.CLK_DIV(2)) dut_a (
        .clk(clk), .reset(rst), .enable(en_a), .clk_ser(cs_a), .clk_par(cp_a),
        .data_ser(ds_a), .m_data(md_a), .m_valid(mv_a), .m_ready(rdy_a),
        .busy(bz_a), .frame_count(fc_a)
    );

    deserializer_ctrl #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(rst), .enable(en_b), .clk_ser(cs_b), .clk_par(cp_b),
        .data_ser(ds_b), .m_data(md_b), .m_valid(mv_b), .m_ready(rdy_b),
        .busy(bz_b), .frame_count(fc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Parallel load while clk_par is low, shift toward Q7 on each clk_ser rise.
    assign ds_a = sreg_a[7];
    assign ds_b = sreg_b[7];

    always @(negedge clk) begin
        if (!cp_a) begin
            if (ppar_a) sreg_a <= (stim_a.size() > 0) ? stim_a.pop_front() : 8'h00;
        end else if (cs_a && !pser_a) begin
            sreg_a <= {sreg_a[6:0], 1'b0};
        end
        ppar_a <= cp_a;
        pser_a <= cs_a;
    end

    always @(negedge clk) begin
        if (!cp_b) begin
            if (ppar_b) sreg_b <= (stim_b.size() > 0) ? stim_b.pop_front() : 8'h00;
        end else if (cs_b && !pser_b) begin
            sreg_b <= {sreg_b[6:0], 1'b0};
        end
        ppar_b <= cp_b;
        pser_b <= cs_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv_a <= 1'b0;
        end else begin
            if (mv_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_a: byte 0x%0h with nothing expected", md_a);
                end else begin
                    e = exp_a.pop_front();
                    check("data_a", {24'h0, md_a}, {24'h0, e.d});
                    check("count_a", {16'h0, fc_a}, {16'h0, e.c});
                end
            end
            if (pv_a && !prdy_a && mv_a) check("hold_a", {24'h0, md_a}, {24'h0, pd_a});
            pv_a <= mv_a;
        end
        prdy_a <= rdy_a;
        pd_a   <= md_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && mv_b && rdy_b) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL spurious_b: byte 0x%0h with nothing expected", md_b);
            end else begin
                e = exp_b.pop_front();
                check("data_b", {24'h0, md_b}, {24'h0, e.d});
                check("count_b", {16'h0, fc_b}, {16'h0, e.c});
            end
        end
    end

    task automatic push(input bit b, input logic [7:0] v, input bit expect_it);
        exp_t e;
        if (!b) begin
            stim_a.push_back(v);
            if (expect_it) begin
                cnt_a++; e.d = v; e.c = cnt_a; exp_a.push_back(e);
            end
        end else begin
            stim_b.push_back(v);
            if (expect_it) begin
                cnt_b++; e.d = v; e.c = cnt_b; exp_b.push_back(e);
            end
        end
    endtask

    function automatic logic par(input bit b);
        return b ? cp_b : cp_a;
    endfunction

    task automatic wait_par_fall(input bit b, output int t);
        int k = 0;
        while (par(b) !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        while (par(b) !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_clk_par: got no fall, expected one within 200 cycles");
        end
        t = cyc;
    endtask

    task automatic wait_valid(input bit b, output int t);
        int k = 0;
        while ((b ? mv_b : mv_a) !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        if (k >= 400) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_m_valid: got none, expected within 400 cycles");
        end
        t = cyc;
    endtask

    task automatic wait_idle(input bit b);
        int k = 0;
        while ((b ? bz_b : bz_a) !== 1'b0 && k < 400) begin @(negedge clk); k++; end
        if (k >= 400) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_idle: got busy, expected idle within 400 cycles");
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_clk_ser"}, {31'h0, cs_a}, 32'h0);
        check({tag, "_clk_par"}, {31'h0, cp_a}, 32'h1);
        check({tag, "_m_data"},  {24'h0, md_a}, 32'h0);
        check({tag, "_m_valid"}, {31'h0, mv_a}, 32'h0);
        check({tag, "_busy"},    {31'h0, bz_a}, 32'h0);
        check({tag, "_fcount"},  {16'h0, fc_a}, 32'h0);
    endtask

    initial begin
        int t0, t1;
        int tf[3];
        cyc = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        cnt_a = '0; cnt_b = '0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        check("rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Single byte, latency from first clk_par low to m_valid
        push(0, 8'hA5, 1);
        en_a = 1'b1;
        wait_par_fall(0, t0);
        en_a = 1'b0;
        wait_valid(0, t1);
        check("latency_a5", t1 - t0, 34);
        repeat (2) @(negedge clk);
        check("idle_after_a5", {31'h0, bz_a}, 32'h0);
        check("fcount_a5", {16'h0, fc_a}, 32'h1);

        // Back-to-back frames
        push(0, 8'h00, 1); push(0, 8'hFF, 1); push(0, 8'h3C, 1);
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) wait_par_fall(0, tf[i]);
        en_a = 1'b0;
        check("period_1", tf[1] - tf[0], 35);
        check("period_2", tf[2] - tf[1], 35);
        wait_idle(0);

        // Consumer stalled: first byte held, second parked in WAIT
        rdy_a = 1'b0;
        push(0, 8'h11, 1); push(0, 8'h22, 1);
        en_a = 1'b1;
        wait_par_fall(0, t0);
        wait_par_fall(0, t0);
        en_a = 1'b0;
        repeat (80) @(negedge clk);
        check("stall_state", 32'(dut_a.state_q), 32'(ST_WAIT));
        check("stall_clk_ser", {31'h0, cs_a}, 32'h0);
        check("stall_clk_par", {31'h0, cp_a}, 32'h1);
        check("stall_busy", {31'h0, bz_a}, 32'h1);
        check("stall_m_data", {24'h0, md_a}, 32'h11);
        check("stall_fcount", {16'h0, fc_a}, 32'h5);
        rdy_a = 1'b1;
        wait_idle(0);
        repeat (2) @(negedge clk);

        // Reset during bit 4 discards the partial byte
        push(0, 8'h5A, 0);
        en_a = 1'b1;
        wait_par_fall(0, t0);
        en_a = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_a("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cnt_a = '0;
        @(negedge clk);
        push(0, 8'h81, 1);
        en_a = 1'b1;
        wait_par_fall(0, t0);
        en_a = 1'b0;
        wait_valid(0, t1);
        check("latency_81", t1 - t0, 34);
        wait_idle(0);

        // frame_count wrap via backdoor preset
        force dut_a.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.frame_count_q;
        @(negedge clk);
        check("preset_fcount", {16'h0, fc_a}, 32'hFFFF);
        cnt_a = 16'hFFFF;
        push(0, 8'hC3, 1);
        en_a = 1'b1;
        wait_par_fall(0, t0);
        en_a = 1'b0;
        wait_valid(0, t1);
        check("wrap_fcount", {16'h0, fc_a}, 32'h0);
        wait_idle(0);

        // CLK_DIV=1 with enable dropped mid-frame
        push(1, 8'h96, 1);
        en_b = 1'b1;
        wait_par_fall(1, t0);
        repeat (4) @(negedge clk);
        en_b = 1'b0;
        wait_valid(1, t1);
        check("latency_div1", t1 - t0, 17);
        repeat (2) @(negedge clk);
        check("div1_busy", {31'h0, bz_b}, 32'h0);
        check("div1_state", 32'(dut_b.state_q), 32'(ST_IDLE));

        repeat (5) @(negedge clk);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
